// File: rtl/jaa_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// FSM state encoding and the opcode-to-length decode.
package jaa_fetch_pkg;

  localparam logic [7:0] OP_PUSH8  = 8'h00;
  localparam logic [7:0] OP_PUSH32 = 8'h01;
  localparam int unsigned MAX_LEN  = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_ARG = 3'd2,
    EMIT      = 3'd3,
    DONE      = 3'd4
  } fetch_state_e;

  // Total instruction length in bytes, opcode included.
  function automatic logic [2:0] insn_len(input logic [7:0] opcode);
    logic [2:0] len;
    case (opcode)
      OP_PUSH8:  len = 3'd2;
      OP_PUSH32: len = 3'd5;
      default:   len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/insn_fetch.sv
// Byte-serial instruction fetch: walks the program ROM from a fetch pointer,
// assembles opcode plus big-endian operand and hands it to the decoder.
module insn_fetch
  import jaa_fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic [ADDR_W-1:0] rom_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [31:0]       out_operand,
  output logic [2:0]        out_len,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_trunc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FPTR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fptr_q, fptr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [31:0]       operand_q, operand_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        remaining_q, remaining_d;
  logic              trunc_q, trunc_d;

  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_opcode_q, out_opcode_d;
  logic [31:0]       out_operand_q, out_operand_d;
  logic [2:0]        out_len_q, out_len_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              out_trunc_q, out_trunc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              past_end_s;
  logic [2:0]        len_s;
  logic [31:0]       shifted_s;

  assign past_end_s = (fptr_q >= rom_size);
  assign len_s      = insn_len(rom_data);
  assign shifted_s  = {operand_q[23:0], rom_data};

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d       = state_q;
    fptr_d        = fptr_q;
    pc_d          = pc_q;
    opcode_d      = opcode_q;
    operand_d     = operand_q;
    len_d         = len_q;
    remaining_d   = remaining_q;
    trunc_d       = trunc_q;
    out_opcode_d  = out_opcode_q;
    out_operand_d = out_operand_q;
    out_len_d     = out_len_q;
    out_pc_d      = out_pc_q;
    out_trunc_d   = out_trunc_q;

    // A redirect overrides everything; a coincident handshake simply completes.
    if ((state_q != IDLE) && redirect_valid) begin
      fptr_d      = redirect_pc;
      operand_d   = 32'h0000_0000;
      trunc_d     = 1'b0;
      remaining_d = 3'd0;
      if (redirect_pc >= rom_size) begin
        state_d = DONE;
      end else begin
        state_d = FETCH_OP;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            fptr_d    = '0;
            pc_d      = '0;
            operand_d = 32'h0000_0000;
            trunc_d   = 1'b0;
            if (rom_size == '0) begin
              state_d = DONE;
            end else begin
              state_d = FETCH_OP;
            end
          end else begin
            state_d = IDLE;
          end
        end

        FETCH_OP: begin
          opcode_d = rom_data;
          pc_d     = fptr_q;
          len_d    = len_s;
          fptr_d   = fptr_q + FPTR_STEP;
          if (len_s == 3'd1) begin
            state_d       = EMIT;
            out_opcode_d  = rom_data;
            out_operand_d = 32'h0000_0000;
            out_len_d     = 3'd1;
            out_pc_d      = fptr_q;
            out_trunc_d   = trunc_q;
          end else begin
            state_d     = FETCH_ARG;
            remaining_d = len_s - 3'd1;
          end
        end

        FETCH_ARG: begin
          // Bytes beyond the program are still shifted in but flag the instruction.
          operand_d   = shifted_s;
          fptr_d      = fptr_q + FPTR_STEP;
          remaining_d = remaining_q - 3'd1;
          trunc_d     = trunc_q | past_end_s;
          if (remaining_q == 3'd1) begin
            state_d       = EMIT;
            out_opcode_d  = opcode_q;
            out_operand_d = shifted_s;
            out_len_d     = len_q;
            out_pc_d      = pc_q;
            out_trunc_d   = trunc_q | past_end_s;
          end else begin
            state_d = FETCH_ARG;
          end
        end

        EMIT: begin
          if (out_ready) begin
            operand_d = 32'h0000_0000;
            trunc_d   = 1'b0;
            if (past_end_s) begin
              state_d = DONE;
            end else begin
              state_d = FETCH_OP;
            end
          end else begin
            state_d = EMIT;
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    out_valid_d = (state_d == EMIT);
    busy_d      = (state_d == FETCH_OP) || (state_d == FETCH_ARG) || (state_d == EMIT);
    done_d      = (state_d == DONE);
  end

  // State, datapath and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fptr_q        <= '0;
      pc_q          <= '0;
      opcode_q      <= 8'h00;
      operand_q     <= 32'h0000_0000;
      len_q         <= 3'd0;
      remaining_q   <= 3'd0;
      trunc_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_opcode_q  <= 8'h00;
      out_operand_q <= 32'h0000_0000;
      out_len_q     <= 3'd0;
      out_pc_q      <= '0;
      out_trunc_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fptr_q        <= fptr_d;
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      len_q         <= len_d;
      remaining_q   <= remaining_d;
      trunc_q       <= trunc_d;
      out_valid_q   <= out_valid_d;
      out_opcode_q  <= out_opcode_d;
      out_operand_q <= out_operand_d;
      out_len_q     <= out_len_d;
      out_pc_q      <= out_pc_d;
      out_trunc_q   <= out_trunc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign rom_addr    = fptr_q;
  assign out_valid   = out_valid_q;
  assign out_opcode  = out_opcode_q;
  assign out_operand = out_operand_q;
  assign out_len     = out_len_q;
  assign out_pc      = out_pc_q;
  assign out_trunc   = out_trunc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: scoreboard of expected instructions
// plus a redirect vector table and hand-written corner sequences.
module tb_insn_fetch;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [AW-1:0] rom_size;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_opcode;
  logic [31:0]   out_operand;
  logic [2:0]    out_len;
  logic [AW-1:0] out_pc;
  logic          out_trunc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  insn_fetch #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_size(rom_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_operand(out_operand), .out_len(out_len),
    .out_pc(out_pc), .out_trunc(out_trunc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .done(done)
  );

  // ROM model: reads beyond the program size return zero.
  logic [7:0] rom [0:255];
  assign rom_data = (rom_addr < rom_size) ? rom[rom_addr[7:0]] : 8'h00;

  typedef struct {
    logic [7:0]    op;
    logic [31:0]   operand;
    logic [2:0]    len;
    logic [AW-1:0] pc;
    logic          trunc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic          exp_done;
    logic [7:0]    op;
    logic [31:0]   operand;
    logic [2:0]    len;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for out_valid", name);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  task automatic do_redirect(input logic [AW-1:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_opcode"}, 32'(out_opcode), 32'h0);
    chk({tag, "_operand"}, out_operand, 32'h0);
    chk({tag, "_len"}, 32'(out_len), 32'h0);
    chk({tag, "_pc"}, 32'(out_pc), 32'h0);
    chk({tag, "_trunc"}, 32'(out_trunc), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Expected instruction stream for a straight walk from start_pc to the end.
  function automatic void push_walk(input int start_pc, input int size);
    int   pc;
    int   n;
    int   a;
    exp_t e;
    pc = start_pc;
    while (pc < size) begin
      e.op      = rom[pc];
      e.pc      = AW'(pc);
      e.operand = 32'h0;
      e.trunc   = 1'b0;
      n = (e.op == 8'h00) ? 2 : ((e.op == 8'h01) ? 5 : 1);
      e.len = 3'(n);
      for (int k = 1; k < n; k++) begin
        a = pc + k;
        if (a >= size) e.trunc = 1'b1;
        e.operand = {e.operand[23:0], (a < size) ? rom[a] : 8'h00};
      end
      sb_q.push_back(e);
      pc = pc + n;
    end
  endfunction

  // Scoreboard: every handshake pops and compares one expected instruction.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      hs_cnt++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got opcode 0x%0h at pc 0x%0h, expected no instruction",
                 out_opcode, out_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_opcode", 32'(out_opcode), 32'(e.op));
        chk("sb_operand", out_operand, e.operand);
        chk("sb_len", 32'(out_len), 32'(e.len));
        chk("sb_pc", 32'(out_pc), 32'(e.pc));
        chk("sb_trunc", 32'(out_trunc), 32'(e.trunc));
      end
    end
  end

  initial begin
    logic [7:0]  h_op;
    logic [AW-1:0] h_pc;
    logic [AW-1:0] h_addr;
    logic [31:0] h_operand;
    int          h0;
    exp_t        e;

    for (int a = 0; a < 256; a++) rom[a] = 8'(8'h40 + a);
    rom[0]  = 8'h66; rom[1]  = 8'h66;
    rom[6]  = 8'h00; rom[7]  = 8'h12;
    rom[18] = 8'h01; rom[19] = 8'h23; rom[20] = 8'h45; rom[21] = 8'h67; rom[22] = 8'h89;
    rom[23] = 8'h03;
    rom[44] = 8'h36;
    rom[48] = 8'h00; rom[49] = 8'h77;

    vecs[0] = '{pc: 16'd6,  exp_done: 1'b0, op: 8'h00, operand: 32'h0000_0012, len: 3'd2};
    vecs[1] = '{pc: 16'd18, exp_done: 1'b0, op: 8'h01, operand: 32'h2345_6789, len: 3'd5};
    vecs[2] = '{pc: 16'd23, exp_done: 1'b0, op: 8'h03, operand: 32'h0000_0000, len: 3'd1};
    vecs[3] = '{pc: 16'd44, exp_done: 1'b0, op: 8'h36, operand: 32'h0000_0000, len: 3'd1};
    vecs[4] = '{pc: 16'd0,  exp_done: 1'b0, op: 8'h66, operand: 32'h0000_0000, len: 3'd1};
    vecs[5] = '{pc: 16'd60, exp_done: 1'b1, op: 8'h00, operand: 32'h0000_0000, len: 3'd0};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; rom_size = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    step();

    // Empty program goes straight to DONE.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("size0_done", 32'(done), 32'h1);
    chk("size0_busy", 32'(busy), 32'h0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("size0_reset_done", 32'(done), 32'h0);

    // Full program walk with the decoder always ready.
    rom_size  = 16'd50;
    out_ready = 1'b1;
    push_walk(0, 50);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_valid_early", 32'(out_valid), 32'h0);
    chk("first_busy", 32'(busy), 32'h1);
    step();
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_opcode", 32'(out_opcode), 32'h66);
    chk("first_pc", 32'(out_pc), 32'h0);
    wait_done("run_done", 300);
    chk("run_done", 32'(done), 32'h1);
    chk("run_busy", 32'(busy), 32'h0);
    chk("run_valid", 32'(out_valid), 32'h0);
    chk("run_sb_empty", 32'(sb_q.size()), 32'h0);

    // Redirect vector table with the decoder stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_redirect(vecs[i].pc);
      if (vecs[i].exp_done) begin
        chk("vec_done", 32'(done), 32'h1);
        chk("vec_done_valid", 32'(out_valid), 32'h0);
      end else begin
        wait_valid("vec_valid");
        chk("vec_opcode", 32'(out_opcode), 32'(vecs[i].op));
        chk("vec_operand", out_operand, vecs[i].operand);
        chk("vec_len", 32'(out_len), 32'(vecs[i].len));
        chk("vec_pc", 32'(out_pc), 32'(vecs[i].pc));
        chk("vec_trunc", 32'(out_trunc), 32'h0);
      end
    end

    // Back-pressure: held outputs and exactly one transfer.
    do_redirect(16'd0);
    wait_valid("hold_valid");
    h_op = out_opcode; h_pc = out_pc; h_addr = rom_addr; h_operand = out_operand;
    chk("hold_addr", 32'(h_addr), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_opcode", 32'(out_opcode), 32'(h_op));
      chk("hold_pc", 32'(out_pc), 32'(h_pc));
      chk("hold_operand", out_operand, h_operand);
      chk("hold_rom_addr", 32'(rom_addr), 32'(h_addr));
    end
    e = '{op: 8'h66, operand: 32'h0, len: 3'd1, pc: 16'd0, trunc: 1'b0};
    sb_q.push_back(e);
    h0 = hs_cnt;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    chk("hold_one_transfer", 32'(hs_cnt - h0), 32'h1);
    chk("hold_sb_empty", 32'(sb_q.size()), 32'h0);

    // Redirect while PUSH32 operand bytes are being collected.
    do_redirect(16'd18);
    step();
    step();
    chk("midarg_busy", 32'(busy), 32'h1);
    chk("midarg_valid", 32'(out_valid), 32'h0);
    do_redirect(16'd44);
    wait_valid("redir_valid");
    chk("redir_opcode", 32'(out_opcode), 32'h36);
    chk("redir_pc", 32'(out_pc), 32'd44);
    chk("redir_len", 32'(out_len), 32'h1);
    chk("redir_operand", out_operand, 32'h0);
    do_redirect(16'd60);
    chk("redir_past_end_done", 32'(done), 32'h1);

    // Truncated PUSH8 at the last program byte.
    rom_size = 16'd49;
    e = '{op: 8'h00, operand: 32'h0, len: 3'd2, pc: 16'd48, trunc: 1'b1};
    sb_q.push_back(e);
    out_ready = 1'b1;
    do_redirect(16'd48);
    wait_done("trunc_done", 20);
    chk("trunc_done", 32'(done), 32'h1);
    chk("trunc_sb_empty", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset in the middle of a PUSH32.
    out_ready = 1'b0;
    do_redirect(16'd18);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #3;
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_valid", 32'(out_valid), 32'h0);
    chk("post_reset_busy", 32'(busy), 32'h0);
    chk("post_reset_done", 32'(done), 32'h0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_fetch.md
# insn_fetch

Instruction fetch stage directly downstream of the program ROM. Walks the ROM one byte per cycle from a program counter and assembles variable-length instructions: opcode plus 0, 1 or 4 big-endian operand bytes. Presents each assembled instruction to the decoder over a valid/ready handshake. Accepts PC redirects from the execute side and stops cleanly at the ROM's reported program size.

## Interface

Parameters:
- `ADDR_W`, default 16: ROM address, PC and size width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins fetching at PC 0. Ignored outside IDLE.
- `rom_addr`  out  ADDR_W  byte address to the ROM; equals internal fetch pointer `fptr`.
- `rom_data`  in  8  ROM byte at `rom_addr`; combinational, valid in the same cycle.
- `rom_size`  in  ADDR_W  program length in bytes; static while running.
- `out_valid`  out  1  assembled instruction available.
- `out_ready`  in  1  decoder accepts the instruction.
- `out_opcode`  out  8  opcode byte.
- `out_operand`  out  32  operand, right-aligned, zero-extended; 0 when there is no operand.
- `out_len`  out  3  instruction length in bytes: 1, 2 or 5.
- `out_pc`  out  ADDR_W  address of the opcode byte.
- `out_trunc`  out  1  instruction ran past `rom_size`.
- `redirect_valid`  in  1  load a new PC.
- `redirect_pc`  in  ADDR_W  target PC.
- `busy`  out  1  state is neither IDLE nor DONE.
- `done`  out  1  state is DONE.

## Operation

Length decode:
- Opcode 0x00 (PUSH8): length 2.
- Opcode 0x01 (PUSH32): length 5.
- All other opcodes: length 1.

States:
- **IDLE**
  - `start` -> FETCH_OP; `fptr`=0, `pc`=0.
  - If `rom_size`==0 at start: -> DONE.
- **FETCH_OP**
  - Latch `rom_data` as the opcode and `pc`=`fptr`; compute length; `fptr`++.
  - Length 1 -> EMIT; otherwise -> FETCH_ARG with `remaining`=len-1.
- **FETCH_ARG**
  - `operand` <= {operand[23:0], rom_data}; `fptr`++; `remaining`--.
  - When `remaining` reaches 0 -> EMIT.
  - A byte fetched with `fptr` >= `rom_size` sets the sticky `trunc` flag; its value is still shifted in (the ROM returns 0 there).
- **EMIT**
  - `out_valid`=1; all `out_*` registered and held stable until the handshake.
  - Handshake: clear `operand`/`trunc`; if `fptr` >= `rom_size` -> DONE, else -> FETCH_OP.
- **DONE**
  - Holds. Leaves only on redirect.

Redirect:
- Applies in any state except IDLE and takes priority over all other transitions.
- Sets `fptr`=`redirect_pc` and discards any partial or held instruction.
- Next state: FETCH_OP, or DONE if `redirect_pc` >= `rom_size`.
- Redirect in the same cycle as an EMIT handshake: the instruction counts as consumed, then the redirect applies.

Width rules:
- `fptr` wraps modulo 2^ADDR_W.
- All comparisons against `rom_size` are unsigned.

Reset values:
- State IDLE.
- `rom_addr`=0, `out_valid`=0, `out_opcode`=0, `out_operand`=0, `out_len`=0, `out_pc`=0, `out_trunc`=0, `busy`=0, `done`=0.
- Reset asserted mid-instruction aborts immediately; no output is produced.

## Timing

- One ROM byte is consumed per cycle in FETCH_OP/FETCH_ARG.
- The opcode is read in the cycle after `start` is sampled.
- An instruction of length L: `out_valid` rises L cycles after its FETCH_OP cycle began, i.e. on cycle L+1 counting FETCH_OP as cycle 1.
- Back-pressure: with `out_ready` low, EMIT holds indefinitely with outputs unchanged.
- Throughput: one instruction per L+1 cycles with `out_ready` tied high.
- `out_valid` drops in the cycle after the handshake or a redirect.
- `done` and `busy` are registered state decodes.

## Structure

- Shared package `jaa_fetch_pkg`:
  - `OP_PUSH8`=8'h00, `OP_PUSH32`=8'h01.
  - Function `insn_len(opcode)` returning 3 bits.
  - State enum {IDLE, FETCH_OP, FETCH_ARG, EMIT, DONE}.
  - `MAX_LEN`=5.
- No sub-module; the length decode is the package function.

## Test plan

- ROM starts 66 66, size 50, `out_ready`=1, `start` pulse -> first `out_valid` 2 cycles after start is sampled with opcode 0x66, len 1, pc 0; second instruction at pc 1.
- Bytes 00 12 at pc 6 -> opcode 0x00, operand 0x00000012, len 2, pc 6.
- Bytes 01 23 45 67 89 at pc 18 -> opcode 0x01, operand 0x23456789, len 5, pc 18; next instruction opcode 0x03 at pc 23.
- Hold `out_ready`=0 for 4 cycles during EMIT -> outputs stable, `rom_addr` unchanged, then exactly one transfer.
- `redirect_valid` with pc 44 mid-FETCH_ARG -> partial instruction dropped; next output opcode 0x36 at pc 44. Redirect to pc 60 -> `done`=1.
- Opcode 00 at pc 48 with size 49 -> operand 0, `out_trunc`=1, then DONE. Assert `rst_n` low mid-PUSH32 -> all outputs return to reset values asynchronously.
